puf_auth_ctrl: RTL and testbench
================================

Name: puf_auth_ctrl

Overview:
- Initiator/verifier for the serialized 8-bit PUF (clk/en/rst/chall_in → response/ready).
- Enroll mode: issues a challenge, stores the challenge and golden response in a slot table.
- Auth mode: re-issues the stored challenge, computes the Hamming distance (HD) against the golden response, and reports pass/fail against a threshold.
- Sits between the host/bus logic and the PUF macro; the PUF's reset, enable and challenge are driven only by this block.

Parameters:
- SLOTS, 4, number of enrollment entries (power of 2, ≥2).
- THRESH, 1, maximum HD (0..8) counted as pass.
- TIMEOUT, 4095, maximum ISSUE cycles waiting for puf_ready before abort (counter 12 bits).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- mode  in  1  0 = authenticate, 1 = enroll; sampled with start.
- slot  in  $clog2(SLOTS)  table index; sampled with start.
- chall  in  8  challenge for enroll; ignored in auth mode.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  auth result; held until the next accepted start.
- hd  out  4  Hamming distance of the last auth (0..8).
- status  out  2  0 OK, 1 TIMEOUT, 2 UNENROLLED.
- puf_rst  out  1  PUF reset pulse.
- puf_en  out  1  PUF enable.
- puf_chall  out  8  challenge to the PUF; stable while puf_en = 1.
- puf_response  in  8  PUF response bus.
- puf_ready  in  1  PUF response valid.

Behaviour:
- Reset:
  - state = IDLE.
  - busy, done, pass, puf_rst, puf_en = 0.
  - hd = 0, status = 0, puf_chall = 0.
  - All slot valid bits cleared; table contents don't-care.
- States: IDLE, CLEAR, ISSUE, EVAL, DONE.
- IDLE: start = 1 latches mode, slot, and the challenge (chall if enroll; table[slot].chall if auth).
  - Auth on an invalid slot → DONE with status = 2, pass = 0, hd = 0. No PUF activity.
  - Otherwise → CLEAR.
- CLEAR (exactly 1 cycle): puf_rst = 1, puf_en = 0, puf_chall = latched challenge, timeout counter = 0 → ISSUE.
- ISSUE: puf_en = 1 and puf_chall held every cycle; timeout counter increments each cycle.
  - First cycle with puf_ready = 1: capture puf_response, puf_en drops the next cycle → EVAL.
  - Counter reaches TIMEOUT with no ready: status = 1, pass = 0, no table write → DONE.
- EVAL (1 cycle):
  - Enroll: write {chall, response} to table[slot], set valid; pass = 1, hd = 0, status = 0.
  - Auth: hd = popcount(resp XOR golden); pass = (hd ≤ THRESH); status = 0.
  - → DONE.
- DONE (1 cycle): done = 1, busy = 0 next cycle → IDLE.
- Result outputs (pass/hd/status) are registered and change only on the EVAL/abort update.
- Latency with the PUF asserting ready R cycles after puf_en rises: start → done = R + 5 cycles.
  - Exception: UNENROLLED takes 2 cycles.
- start while busy: ignored, no queuing.
- start in the same cycle as done: ignored (the FSM is in DONE).
- puf_ready high outside ISSUE: ignored.
- Re-enrolling a valid slot: overwrites it.
- rst mid-operation: immediate return to IDLE, puf_en = 0, table invalidated.

Optional Feature:
- Macro: PUF_AUTH_VOTE_EN.
- Defined:
  - Each operation runs 3 CLEAR/ISSUE rounds with the same challenge.
  - Captured responses are combined by bitwise 2-of-3 majority before EVAL (enroll stores the majority).
  - A timeout in any round aborts the whole operation.
  - Latency = 3·(R + 2) + 3 cycles.
- Undefined: single round as described above.

Decomposition:
- Package puf_auth_pkg holds:
  - state enum;
  - status codes ST_OK = 0, ST_TIMEOUT = 1, ST_UNENROLLED = 2;
  - RESP_W = 8;
  - VOTES = 3;
  - timeout counter width = 12.
- One sub-module, puf_hamming: combinational 8-bit XOR + popcount, outputs 4 bits, instantiated in EVAL.

Test Plan:
- Enroll slot 1, chall = 0x5A; PUF model returns 0xC3 with ready 10 cycles after puf_en → done at start + 15, status = 0; then auth slot 1 with model returning 0xC3 → puf_chall = 0x5A, hd = 0, pass = 1.
- Auth slot 1 with model returning 0xC1 (1 bit flipped), THRESH = 1 → hd = 1, pass = 1; with 0x03 → hd = 2, pass = 0.
- Auth slot 2, never enrolled → done 2 cycles after start, status = 2, pass = 0, puf_en never asserted.
- Model never asserts ready → done after TIMEOUT ISSUE cycles, status = 1; a later auth of the slot shows the table unchanged.
- start pulsed during ISSUE, and rst asserted mid-ISSUE → the extra start is ignored; on reset puf_en = 0 immediately and a later auth of the previously enrolled slot returns status = 2.
- With PUF_AUTH_VOTE_EN: enroll with rounds 0xF0/0xF1/0xF0 → stored 0xF0; auth with rounds 0x0F/0xF0/0xF0 → hd = 0, pass = 1.

Source files
------------

// File: rtl/puf_auth_pkg.sv
// Shared types and constants for the PUF authentication controller.
package puf_auth_pkg;

  localparam int unsigned RESP_W   = 8;
  localparam int unsigned VOTES    = 3;
  localparam int unsigned TO_CNT_W = 12;
  localparam int unsigned HD_W     = 4;
  localparam int unsigned STATUS_W = 2;
  localparam int unsigned ROUND_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_EVAL,
    S_DONE
  } state_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK         = 2'd0,
    ST_TIMEOUT    = 2'd1,
    ST_UNENROLLED = 2'd2
  } status_e;

  // One enrollment record: issued challenge and its golden response.
  typedef struct packed {
    logic [RESP_W-1:0] chall;
    logic [RESP_W-1:0] resp;
  } slot_entry_t;

  // Bitwise 2-of-3 majority across repeated PUF reads.
  function automatic logic [RESP_W-1:0] maj3(input logic [RESP_W-1:0] a,
                                             input logic [RESP_W-1:0] b,
                                             input logic [RESP_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/puf_auth_ctrl_if.sv
// Host request/result signals plus the PUF macro link.
// slave: controller view; master: host/PUF environment view.
interface puf_auth_ctrl_if
  import puf_auth_pkg::*;
#(
  parameter int unsigned SLOTS = 4
) ();

  localparam int unsigned SLOT_W = $clog2(SLOTS);

  logic                start;
  logic                mode;
  logic [SLOT_W-1:0]   slot;
  logic [RESP_W-1:0]   chall;
  logic                busy;
  logic                done;
  logic                pass;
  logic [HD_W-1:0]     hd;
  logic [STATUS_W-1:0] status;
  logic                puf_rst;
  logic                puf_en;
  logic [RESP_W-1:0]   puf_chall;
  logic [RESP_W-1:0]   puf_response;
  logic                puf_ready;

  modport slave (
    input  start, mode, slot, chall, puf_response, puf_ready,
    output busy, done, pass, hd, status, puf_rst, puf_en, puf_chall
  );

  modport master (
    output start, mode, slot, chall, puf_response, puf_ready,
    input  busy, done, pass, hd, status, puf_rst, puf_en, puf_chall
  );

endinterface

// File: rtl/puf_hamming.sv
// Combinational Hamming distance between a PUF response and its golden value.
module puf_hamming
  import puf_auth_pkg::*;
(
  input  logic [RESP_W-1:0] a_i,
  input  logic [RESP_W-1:0] b_i,
  output logic [HD_W-1:0]   hd_c_o
);

  logic [RESP_W-1:0] diff;

  assign diff = a_i ^ b_i;

  // Popcount of differing bits.
  always_comb begin
    hd_c_o = '0;
    for (int unsigned i = 0; i < RESP_W; i++) begin
      hd_c_o = hd_c_o + HD_W'(diff[i]);
    end
  end

endmodule

// File: rtl/puf_auth_ctrl.sv
// PUF enrollment/authentication controller.
// Enroll stores {challenge, response} per slot; auth re-issues the stored
// challenge and grades the Hamming distance against THRESH.
// Optional macro PUF_AUTH_VOTE_EN: three read rounds per operation,
// combined by bitwise 2-of-3 majority.
module puf_auth_ctrl
  import puf_auth_pkg::*;
#(
  parameter int unsigned SLOTS   = 4,
  parameter int unsigned THRESH  = 1,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  puf_auth_ctrl_if.slave        bus
);

  localparam int unsigned SLOT_W = $clog2(SLOTS);
`ifdef PUF_AUTH_VOTE_EN
  localparam int unsigned N_ROUNDS = VOTES;
`else
  localparam int unsigned N_ROUNDS = 1;
`endif

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [RESP_W-1:0]   chall_q, chall_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic [RESP_W-1:0]   resp_q [N_ROUNDS];
  logic [RESP_W-1:0]   resp_fin;
  logic                cap_en;
  logic                tbl_we;

  slot_entry_t         tbl_q [SLOTS];
  logic [SLOTS-1:0]    valid_q;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [HD_W-1:0]     hd_q, hd_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                puf_rst_q, puf_rst_d;
  logic                puf_en_q, puf_en_d;
  logic [RESP_W-1:0]   puf_chall_q;
  logic [HD_W-1:0]     hd_c;

  // Final response seen by EVAL: single read or majority of three.
`ifdef PUF_AUTH_VOTE_EN
  assign resp_fin = maj3(resp_q[0], resp_q[1], resp_q[2]);
`else
  assign resp_fin = resp_q[0];
`endif

  puf_hamming u_hamming (
    .a_i    (resp_fin),
    .b_i    (tbl_q[slot_q].resp),
    .hd_c_o (hd_c)
  );

  // Next-state, datapath control and next values of registered outputs.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    slot_d   = slot_q;
    chall_d  = chall_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    cap_en   = 1'b0;
    tbl_we   = 1'b0;
    pass_d   = pass_q;
    hd_d     = hd_q;
    status_d = status_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          slot_d  = bus.slot;
          chall_d = bus.mode ? bus.chall : tbl_q[bus.slot].chall;
          round_d = '0;
          if (!bus.mode && !valid_q[bus.slot]) begin
            pass_d   = 1'b0;
            hd_d     = '0;
            status_d = ST_UNENROLLED;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d = cnt_q + TO_CNT_W'(1);
        if (bus.puf_ready) begin
          cap_en = 1'b1;
          if (round_q == ROUND_W'(N_ROUNDS - 1)) begin
            state_d = S_EVAL;
          end else begin
            round_d = round_q + ROUND_W'(1);
            state_d = S_CLEAR;
          end
        end else if (cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          pass_d   = 1'b0;
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end
      S_EVAL: begin
        if (mode_q) begin
          tbl_we = 1'b1;
          pass_d = 1'b1;
          hd_d   = '0;
        end else begin
          hd_d   = hd_c;
          pass_d = (hd_c <= HD_W'(THRESH));
        end
        status_d = ST_OK;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    puf_rst_d = (state_d == S_CLEAR);
    puf_en_d  = (state_d == S_ISSUE);
  end

  // State, operation context, captured responses and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      slot_q      <= '0;
      chall_q     <= '0;
      cnt_q       <= '0;
      round_q     <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      hd_q        <= '0;
      status_q    <= ST_OK;
      puf_rst_q   <= 1'b0;
      puf_en_q    <= 1'b0;
      puf_chall_q <= '0;
      for (int unsigned i = 0; i < N_ROUNDS; i++) begin
        resp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      slot_q    <= slot_d;
      chall_q   <= chall_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      hd_q      <= hd_d;
      status_q  <= status_d;
      puf_rst_q <= puf_rst_d;
      puf_en_q  <= puf_en_d;
      if (state_d == S_CLEAR) begin
        puf_chall_q <= chall_d;
      end
      if (tbl_we) begin
        valid_q[slot_q] <= 1'b1;
      end
      for (int unsigned i = 0; i < N_ROUNDS; i++) begin
        if (cap_en && (round_q == ROUND_W'(i))) begin
          resp_q[i] <= bus.puf_response;
        end
      end
    end
  end

  // Table payload; meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[slot_q] <= '{chall: chall_q, resp: resp_fin};
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.hd        = hd_q;
  assign bus.status    = status_q;
  assign bus.puf_rst   = puf_rst_q;
  assign bus.puf_en    = puf_en_q;
  assign bus.puf_chall = puf_chall_q;

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Directed self-checking bench for puf_auth_ctrl with a behavioural PUF.
// Build with PUF_AUTH_VOTE_EN defined to exercise the majority-vote rounds.
module tb_puf_auth_ctrl;

  localparam int unsigned SLOTS   = 4;
  localparam int unsigned THRESH  = 1;
  localparam int unsigned TIMEOUT = 4095;
`ifdef PUF_AUTH_VOTE_EN
  localparam int ROUNDS = 3;
`else
  localparam int ROUNDS = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  puf_auth_ctrl_if #(.SLOTS(SLOTS)) bus ();

  puf_auth_ctrl #(
    .SLOTS   (SLOTS),
    .THRESH  (THRESH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // PUF model: ready for one cycle model_r cycles after puf_en rises.
  int         model_r = -1;
  logic [7:0] model_resp [3] = '{8'h00, 8'h00, 8'h00};
  int         rdy_base  = 0;
  int         ready_cnt = 0;
  int         en_cycles = 0;
  int         en_cnt    = 0;
  logic [7:0] seen_chall = 8'h00;

  always @(negedge clk) begin
    if (rst || bus.puf_rst || !bus.puf_en) begin
      en_cnt        = 0;
      bus.puf_ready = 1'b0;
    end else begin
      en_cycles++;
      seen_chall = bus.puf_chall;
      if (model_r >= 0 && en_cnt == model_r) begin
        bus.puf_ready    = 1'b1;
        bus.puf_response = model_resp[(ready_cnt - rdy_base) % 3];
        ready_cnt++;
      end else begin
        bus.puf_ready = 1'b0;
      end
      en_cnt++;
    end
  end

  // Runs one request; lat counts cycles from the start cycle to the done
  // cycle inclusive (-1 if done never came). inj_k > 0 pulses an extra
  // start (auth, slot 2) in that cycle. Returns in the cycle after done.
  task automatic do_op(input logic m, input logic [1:0] s, input logic [7:0] c,
                       input int r, input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] r2, input int inj_k, output int lat);
    model_r       = r;
    model_resp[0] = r0;
    model_resp[1] = r1;
    model_resp[2] = r2;
    rdy_base      = ready_cnt;
    lat           = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.slot  = s;
    bus.chall = c;
    for (int k = 1; k < 6000; k++) begin
      @(negedge clk);
      bus.start = (k == inj_k);
      if (k == inj_k) begin
        bus.mode  = 1'b0;
        bus.slot  = 2'd2;
        bus.chall = 8'hEE;
      end
      if (bus.done) begin
        lat = k + 1;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.slot  = '0;
    bus.chall = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    checks++; if (bus.pass !== 1'b0)    begin errors++; $display("FAIL reset_pass got %0b exp 0", bus.pass); end
    checks++; if (bus.hd !== 4'd0)      begin errors++; $display("FAIL reset_hd got %0d exp 0", bus.hd); end
    checks++; if (bus.status !== 2'd0)  begin errors++; $display("FAIL reset_status got %0d exp 0", bus.status); end
    checks++; if (bus.puf_rst !== 1'b0) begin errors++; $display("FAIL reset_puf_rst got %0b exp 0", bus.puf_rst); end
    checks++; if (bus.puf_en !== 1'b0)  begin errors++; $display("FAIL reset_puf_en got %0b exp 0", bus.puf_en); end
    checks++; if (bus.puf_chall !== 8'h00) begin errors++; $display("FAIL reset_puf_chall got %h exp 00", bus.puf_chall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enroll();
    int lat;
    do_op(1'b1, 2'd1, 8'h5A, 10, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    checks++; if (lat !== ROUNDS * 12 + 3) begin errors++; $display("FAIL enroll_latency got %0d exp %0d", lat, ROUNDS * 12 + 3); end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL enroll_status got %0d exp 0", bus.status); end
    checks++; if (bus.pass !== 1'b1)   begin errors++; $display("FAIL enroll_pass got %0b exp 1", bus.pass); end
    checks++; if (seen_chall !== 8'h5A) begin errors++; $display("FAIL enroll_puf_chall got %h exp 5a", seen_chall); end
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL enroll_busy_after got %0b exp 0", bus.busy); end
  endtask

  task automatic test_auth_match();
    int lat;
    do_op(1'b0, 2'd1, 8'hFF, 10, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    checks++; if (lat !== ROUNDS * 12 + 3) begin errors++; $display("FAIL auth_latency got %0d exp %0d", lat, ROUNDS * 12 + 3); end
    checks++; if (seen_chall !== 8'h5A) begin errors++; $display("FAIL auth_puf_chall got %h exp 5a", seen_chall); end
    checks++; if (bus.hd !== 4'd0)     begin errors++; $display("FAIL auth_hd got %0d exp 0", bus.hd); end
    checks++; if (bus.pass !== 1'b1)   begin errors++; $display("FAIL auth_pass got %0b exp 1", bus.pass); end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL auth_status got %0d exp 0", bus.status); end
  endtask

  task automatic test_auth_thresh();
    int lat;
    do_op(1'b0, 2'd1, 8'h00, 4, 8'hC1, 8'hC1, 8'hC1, 0, lat);
    checks++; if (bus.hd !== 4'd1)   begin errors++; $display("FAIL thresh1_hd got %0d exp 1", bus.hd); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL thresh1_pass got %0b exp 1", bus.pass); end
    do_op(1'b0, 2'd1, 8'h00, 0, 8'h03, 8'h03, 8'h03, 0, lat);
    checks++; if (bus.hd !== 4'd2)   begin errors++; $display("FAIL thresh2_hd got %0d exp 2", bus.hd); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL thresh2_pass got %0b exp 0", bus.pass); end
    checks++; if (lat !== ROUNDS * 2 + 3) begin errors++; $display("FAIL thresh2_latency got %0d exp %0d", lat, ROUNDS * 2 + 3); end
  endtask

  task automatic test_unenrolled();
    int lat;
    int en_before;
    do_op(1'b0, 2'd1, 8'h00, 2, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    en_before = en_cycles;
    do_op(1'b0, 2'd2, 8'h00, 2, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    checks++; if (lat !== 2)           begin errors++; $display("FAIL unenr_latency got %0d exp 2", lat); end
    checks++; if (bus.status !== 2'd2) begin errors++; $display("FAIL unenr_status got %0d exp 2", bus.status); end
    checks++; if (bus.pass !== 1'b0)   begin errors++; $display("FAIL unenr_pass got %0b exp 0", bus.pass); end
    checks++; if (bus.hd !== 4'd0)     begin errors++; $display("FAIL unenr_hd got %0d exp 0", bus.hd); end
    checks++; if (en_cycles !== en_before) begin errors++; $display("FAIL unenr_puf_en got %0d cycles exp 0", en_cycles - en_before); end
  endtask

  task automatic test_timeout();
    int lat;
    do_op(1'b0, 2'd1, 8'h00, 3, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL pre_timeout_pass got %0b exp 1", bus.pass); end
    do_op(1'b1, 2'd1, 8'h11, -1, 8'h00, 8'h00, 8'h00, 0, lat);
    checks++; if (lat !== TIMEOUT + 3) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", lat, TIMEOUT + 3); end
    checks++; if (bus.status !== 2'd1) begin errors++; $display("FAIL timeout_status got %0d exp 1", bus.status); end
    checks++; if (bus.pass !== 1'b0)   begin errors++; $display("FAIL timeout_pass got %0b exp 0", bus.pass); end
    do_op(1'b0, 2'd1, 8'h00, 5, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    checks++; if (seen_chall !== 8'h5A) begin errors++; $display("FAIL post_timeout_chall got %h exp 5a", seen_chall); end
    checks++; if (bus.hd !== 4'd0)     begin errors++; $display("FAIL post_timeout_hd got %0d exp 0", bus.hd); end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL post_timeout_status got %0d exp 0", bus.status); end
  endtask

  task automatic test_busy_start();
    int lat;
    int extra_done;
    do_op(1'b1, 2'd3, 8'h33, 10, 8'h96, 8'h96, 8'h96, 5, lat);
    checks++; if (lat !== ROUNDS * 12 + 3) begin errors++; $display("FAIL busy_start_latency got %0d exp %0d", lat, ROUNDS * 12 + 3); end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL busy_start_status got %0d exp 0", bus.status); end
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra_done++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL busy_start_queued got %0d active cycles exp 0", extra_done); end
    do_op(1'b0, 2'd3, 8'h00, 1, 8'h96, 8'h96, 8'h96, ROUNDS * 3 + 2, lat);
    checks++; if (seen_chall !== 8'h33) begin errors++; $display("FAIL slot3_chall got %h exp 33", seen_chall); end
    checks++; if (bus.hd !== 4'd0 || bus.pass !== 1'b1) begin errors++; $display("FAIL slot3_result got hd %0d pass %0b exp hd 0 pass 1", bus.hd, bus.pass); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_on_done got busy %0b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_op(1'b1, 2'd0, 8'hA5, 3, 8'h3C, 8'h3C, 8'h3C, 0, lat);
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL slot0_enroll_pass got %0b exp 1", bus.pass); end
    model_r = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.slot  = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.puf_en !== 1'b1) begin errors++; $display("FAIL mid_issue_puf_en got %0b exp 1", bus.puf_en); end
    rst = 1'b1;
    #1;
    checks++; if (bus.puf_en !== 1'b0) begin errors++; $display("FAIL rst_puf_en got %0b exp 0", bus.puf_en); end
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %0b exp 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 2'd0, 8'h00, 3, 8'h3C, 8'h3C, 8'h3C, 0, lat);
    checks++; if (lat !== 2 || bus.status !== 2'd2) begin errors++; $display("FAIL rst_slot0_invalid got lat %0d status %0d exp lat 2 status 2", lat, bus.status); end
    do_op(1'b0, 2'd1, 8'h00, 3, 8'hC3, 8'hC3, 8'hC3, 0, lat);
    checks++; if (bus.status !== 2'd2) begin errors++; $display("FAIL rst_slot1_invalid got status %0d exp 2", bus.status); end
  endtask

`ifdef PUF_AUTH_VOTE_EN
  task automatic test_vote();
    int lat;
    do_op(1'b1, 2'd1, 8'h77, 2, 8'hF0, 8'hF1, 8'hF0, 0, lat);
    checks++; if (lat !== 3 * 4 + 3) begin errors++; $display("FAIL vote_latency got %0d exp 15", lat); end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL vote_enroll_status got %0d exp 0", bus.status); end
    do_op(1'b0, 2'd1, 8'h00, 2, 8'h0F, 8'hF0, 8'hF0, 0, lat);
    checks++; if (seen_chall !== 8'h77) begin errors++; $display("FAIL vote_chall got %h exp 77", seen_chall); end
    checks++; if (bus.hd !== 4'd0)   begin errors++; $display("FAIL vote_hd got %0d exp 0", bus.hd); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL vote_pass got %0b exp 1", bus.pass); end
  endtask
`endif

  initial begin
    test_reset();
    test_enroll();
    test_auth_match();
    test_auth_thresh();
    test_unenrolled();
    test_timeout();
    test_busy_start();
    test_reset_mid();
`ifdef PUF_AUTH_VOTE_EN
    test_vote();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
